// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: WIDTH-bit word in over valid/ready, one bit per clk out.
// Define PIPO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

`ifdef PIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par_q, par_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             serial_q, serial_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

`ifdef PIPO_PARITY_EN
    assign in_ready = !rst && ((state_q == IDLE) || (state_q == PARITY));
`else
    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST)));
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
`ifdef PIPO_PARITY_EN
        par_d    = par_q;
`endif
        serial_d = 1'b0;
        frame_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            SHIFT: begin
                if (cnt_q != LAST) begin
                    cnt_d    = cnt_q + CW'(1);
                    sh_d     = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
                    serial_d = (LSB_FIRST != 0) ? sh_q[1] : sh_q[WIDTH-2];
                    frame_d  = 1'b1;
                    busy_d   = 1'b1;
`ifndef PIPO_PARITY_EN
                    done_d   = (cnt_q == PRE);
`endif
                end else begin
                    cnt_d = '0;
                    sh_d  = '0;
`ifdef PIPO_PARITY_EN
                    state_d  = PARITY;
                    serial_d = par_q;
                    frame_d  = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b1;
`else
                    state_d  = IDLE;
`endif
                end
            end
`ifdef PIPO_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // Accept overrides the end-of-frame return to IDLE, giving back-to-back frames.
        if (accept) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            sh_d     = par_in;
            serial_d = (LSB_FIRST != 0) ? par_in[0] : par_in[WIDTH-1];
            frame_d  = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
`ifdef PIPO_PARITY_EN
            par_d    = ^par_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            serial_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PIPO_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            serial_q <= serial_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PIPO_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign frame_out  = frame_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// compared against a queue-of-pending-bits reference model.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PIPO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] par_in = '0;
    logic rdy0, ser0, frm0, bsy0, dn0;
    logic rdy1, ser1, frm1, bsy1, dn1;

    piso_tx #(.WIDTH(W), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .par_in(par_in), .in_valid(in_valid), .in_ready(rdy0),
        .serial_out(ser0), .frame_out(frm0), .busy(bsy0), .done(dn0));
    piso_tx #(.WIDTH(W), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .par_in(par_in), .in_valid(in_valid), .in_ready(rdy1),
        .serial_out(ser1), .frame_out(frm1), .busy(bsy1), .done(dn1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending bits not yet on the line: {bit, last_of_frame}.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    // Bit currently on the line: {valid, bit, last_of_frame}.
    logic [2:0] cur0 = '0;
    logic [2:0] cur1 = '0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
        logic acc;
        logic bm, bl;
        rst = r; in_valid = v; par_in = d;
        #1;
        chk("in_ready_msb", rdy0, !r && (q0.size() == 0));
        chk("in_ready_lsb", rdy1, !r && (q1.size() == 0));
        acc = v && !r && (q0.size() == 0);
        @(posedge clk);
        if (r) begin
            q0.delete(); q1.delete();
            cur0 = '0; cur1 = '0;
        end else begin
            if (acc) begin
                for (int i = 0; i < FLEN; i++) begin
                    if (i < W) begin
                        bm = d[W-1-i];
                        bl = d[i];
                    end else begin
                        bm = ^d;
                        bl = ^d;
                    end
                    q0.push_back({bm, i == FLEN - 1});
                    q1.push_back({bl, i == FLEN - 1});
                end
            end
            cur0 = (q0.size() != 0) ? {1'b1, q0.pop_front()} : 3'b000;
            cur1 = (q1.size() != 0) ? {1'b1, q1.pop_front()} : 3'b000;
        end
        @(negedge clk);
        chk("serial_msb", ser0, cur0[2] & cur0[1]);
        chk("frame_msb",  frm0, cur0[2]);
        chk("busy_msb",   bsy0, cur0[2]);
        chk("done_msb",   dn0,  cur0[2] & cur0[0]);
        chk("serial_lsb", ser1, cur1[2] & cur1[1]);
        chk("frame_lsb",  frm1, cur1[2]);
        chk("busy_lsb",   bsy1, cur1[2]);
        chk("done_lsb",   dn1,  cur1[2] & cur1[0]);
    endtask

    initial begin
        // Reset, then idle
        repeat (3) cyc(1'b1, 1'b1, 8'hFF);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);

        // Single frame 0xA5, then idle
        cyc(1'b0, 1'b1, 8'hA5);
        repeat (FLEN + 2) cyc(1'b0, 1'b0, 8'h00);

        // 0x01 (LSB-first instance sends 1 then zeros)
        cyc(1'b0, 1'b1, 8'h01);
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        // Back-to-back: 0xA5 then 0x3C held valid, taken on the final cycle
        cyc(1'b0, 1'b1, 8'hA5);
        repeat (FLEN) cyc(1'b0, 1'b1, 8'h3C);
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        // 0x07 (odd parity when enabled)
        cyc(1'b0, 1'b1, 8'h07);
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        // Stall: valid held, data changing every cycle
        cyc(1'b0, 1'b1, 8'hC3);
        repeat (FLEN + 3) cyc(1'b0, 1'b1, W'($urandom));
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        // Reset while bit 4 of 0xFF is on the line, then 0x80
        cyc(1'b0, 1'b1, 8'hFF);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 8'h55);
        cyc(1'b0, 1'b1, 8'h80);
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, W'($urandom));
        repeat (FLEN + 1) cyc(1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in, serial-out transmitter that pairs with the team's serial shift-register receivers. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a one-bit serial line, one bit per clk. A frame strobe marks the active bits for the far-end receiver. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, data word width in bits (must be >= 2)
LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
par_in  input  WIDTH  word to transmit, sampled on handshake
in_valid  input  1  par_in holds a word
in_ready  output  1  transmitter can accept a word this cycle
serial_out  output  1  serial data bit
frame_out  output  1  high while serial_out carries a frame bit
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse coincident with the final bit of a frame

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: serial_out=0, frame_out=0, busy=0, done=0, state=IDLE, bit counter=0, shift register=0. in_ready is forced 0 while rst=1.
- Handshake: word accepted on a posedge where in_valid=1 and in_ready=1. par_in is ignored at every other posedge. in_valid may be held across stall cycles without effect.
- States: IDLE, SHIFT (plus PARITY when PARITY_EN is defined).
- IDLE: in_ready=1, serial_out=0, frame_out=0, busy=0. On accept, go to SHIFT.
- Latency: the first bit appears on serial_out in the cycle after acceptance. Each bit is held exactly one cycle. A frame is WIDTH cycles long.
- Bit order:
  - LSB_FIRST=0: bit WIDTH-1 first, down to bit 0.
  - LSB_FIRST=1: bit 0 first, up to bit WIDTH-1.
- SHIFT:
  - frame_out=1 and busy=1.
  - The bit counter runs 0 to WIDTH-1 and never wraps beyond WIDTH-1.
  - in_ready=1 only on the final-bit cycle (counter = WIDTH-1); 0 otherwise.
- End of frame:
  - If a word is accepted on the final-bit cycle, the next word's first bit follows immediately. State stays SHIFT, counter reloads to 0, frame_out stays 1.
  - Otherwise, return to IDLE. serial_out=0 and frame_out=0 in the next cycle.
- done: 1 exactly on the last bit cycle of each frame (registered with that bit), including back-to-back frames.
- Output registers: serial_out, frame_out, busy and done are all registered. in_ready is a combinational decode of state, counter and rst.
- Reset mid-frame: the frame is aborted. All outputs take reset values in the cycle after the rst posedge. The partial word is discarded and not resumed.
- in_valid=0 on the final-bit cycle: no accept, return to IDLE, no spurious bit.

Optional Feature:
Macro: PIPO_PARITY_EN
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of all data bits) is sent in state PARITY, with frame_out=1 and busy=1.
  - The frame is WIDTH+1 cycles long.
  - in_ready and done move to the PARITY cycle; in_ready=0 on the last data bit.
  - Back-to-back accept occurs on the PARITY cycle.
- Undefined: no PARITY state, no parity logic, frame is WIDTH cycles.

Test Plan:
- WIDTH=8, LSB_FIRST=0, accept 8'hA5 from IDLE -> serial_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept. frame_out=1 for exactly those 8 cycles. done=1 on cycle 8 only. Then IDLE with serial_out=0.
- LSB_FIRST=1, accept 8'h01 -> serial_out 1 then seven 0s. done on the 8th bit.
- Back-to-back: 8'hA5 accepted, then 8'h3C presented with in_valid held -> accepted on the final bit of A5. Stream is 10100101 00111100 with no gap. frame_out is continuously 1 for 16 cycles. done pulses on cycles 8 and 16.
- Stall: in_valid=1 with par_in changing during cycles 1..7 of a frame -> no accept (in_ready=0). Frame bits are unaffected.
- Reset mid-frame: rst=1 during bit 4 of 8'hFF -> next cycle serial_out=0, frame_out=0, busy=0, done=0. in_ready=0 while rst=1, then 1 after rst drops. A new word 8'h80 transmits cleanly as 1 then seven 0s.
- PIPO_PARITY_EN defined:
  - 8'hA5 -> 9-bit frame ending in parity 0.
  - 8'h07 -> parity 1.
  - done and in_ready fall on bit 9.
  - A back-to-back word starts on the following cycle.
